// File: rtl/ifft_sdf_ctrl_if.sv
// ifft_sdf_ctrl_if: sample strobes into the sequencer, stage controls and output framing out
interface ifft_sdf_ctrl_if;
  logic in_valid, in_first;
  logic [4:0] stage_en, bf_sel;
  logic [19:0] tw_addr;
  logic out_valid, out_first;
  logic [4:0] out_idx;
  logic err_sync;
  modport master (output in_valid, in_first, input stage_en, bf_sel, tw_addr, out_valid, out_first, out_idx, err_sync);
  modport slave (input in_valid, in_first, output stage_en, bf_sel, tw_addr, out_valid, out_first, out_idx, err_sync);
endinterface

// File: rtl/ifft_sdf_ctrl.sv
// ifft_sdf_ctrl: 32-point R2SDF IFFT sequencer; define IFFT_SYNC_CHECK_EN for in_first resync and err_sync
module ifft_sdf_ctrl #(parameter int STAGE_LAT = 1) (
  input logic clk,
  input logic rst,
  ifft_sdf_ctrl_if.slave bus
);
  logic [4:0] v, f, vo, fo, bf, primed;
  logic [4:0] c [5];
  logic [4:0] cur [5];
  logic [4:0] pc [5];
  logic [4:0] pv [STAGE_LAT];
  logic [4:0] pf [STAGE_LAT];
  logic [19:0] tw;
  logic [4:0] k, kc;
  logic f0, err, ov, of;
`ifdef IFFT_SYNC_CHECK_EN
  assign f0 = v[0] & bus.in_first;
  // sticky flag: frame start seen while stage 0 is mid-frame
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if (f0 && c[0] != 5'd0) err <= 1'b1;
`else
  logic seen;
  assign f0 = v[0] & bus.in_first & ~seen;
  assign err = 1'b0;
  // only the first valid after reset may carry a frame start
  always_ff @(posedge clk or negedge rst)
    if (!rst) seen <= 1'b0;
    else if (v[0]) seen <= 1'b1;
`endif
  assign v = {pv[STAGE_LAT-1][3:0], bus.in_valid & rst};
  assign f = {pf[STAGE_LAT-1][3:0], f0};
  assign ov = pv[STAGE_LAT-1][4];
  assign of = pf[STAGE_LAT-1][4];
  assign kc = of ? 5'd0 : k;
  // per-stage phase select, twiddle address and output framing for the current sample
  always_comb begin
    tw = '0;
    for (int s = 0; s < 5; s++) begin
      primed[s] = pc[s] == 5'(16 >> s);
      cur[s] = f[s] ? 5'd0 : c[s];
      bf[s] = v[s] & cur[s][4-s];
      vo[s] = v[s] & primed[s];
      fo[s] = vo[s] & (c[s] == 5'(16 >> s));
      if (v[s] & ~bf[s] & primed[s]) tw[4*s +: 4] = 4'((cur[s] & 5'((16 >> s) - 1)) << s);
    end
  end
  // sample counters, priming counters and the inter-stage valid/first delay lines
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int s = 0; s < 5; s++) begin
        c[s] <= '0;
        pc[s] <= '0;
      end
      for (int i = 0; i < STAGE_LAT; i++) begin
        pv[i] <= '0;
        pf[i] <= '0;
      end
    end else begin
      for (int s = 0; s < 5; s++) begin
        if (v[s]) c[s] <= cur[s] + 5'd1;
        if (v[s] & ~primed[s]) pc[s] <= pc[s] + 5'd1;
      end
      pv[0] <= vo;
      pf[0] <= fo;
      for (int i = 1; i < STAGE_LAT; i++) begin
        pv[i] <= pv[i-1];
        pf[i] <= pf[i-1];
      end
    end
  // output sample counter, restarted by each output frame start
  always_ff @(posedge clk or negedge rst)
    if (!rst) k <= '0;
    else if (ov) k <= kc + 5'd1;
  assign bus.stage_en = v;
  assign bus.bf_sel = bf;
  assign bus.tw_addr = tw;
  assign bus.out_valid = ov;
  assign bus.out_first = of;
  assign bus.out_idx = ov ? {kc[0], kc[1], kc[2], kc[3], kc[4]} : 5'd0;
  assign bus.err_sync = err;
endmodule

// File: doc/ifft_sdf_ctrl.md
# ifft_sdf_ctrl

Sequencer for the 32-point radix-2 single-path delay-feedback (R2SDF) IFFT pipeline. It tracks samples through the five delay-feedback FIFO stages, which have delays of 16, 8, 4, 2 and 1. It drives each stage's butterfly/fill select, shift enable and twiddle-ROM address, and produces output framing with a bit-reversed output index. It sits beside the datapath and carries no data itself.

## Interface
- `STAGE_LAT`, default 1: register cycles per stage between stage input and the next stage's input (1..4).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a sample (`dir`/`dii`) is presented to stage 0 this cycle.
- `in_first`  in  1  qualified by `in_valid`; marks sample 0 of a frame.
- `stage_en`  out  5  bit s: stage s delay line shifts this cycle.
- `bf_sel`  out  5  bit s: 1 = butterfly phase (sum out, difference into FIFO); 0 = fill/drain phase.
- `tw_addr`  out  20  4 bits per stage, stage s at [4s+3:4s]; index into the 16-entry W32 ROM.
- `out_valid`  out  1  pipeline output sample valid.
- `out_first`  out  1  output sample is index 0 of a frame.
- `out_idx`  out  5  natural-order frequency index of the current output sample.
- `err_sync`  out  1  sticky framing error (see Configuration).

## Operation
- Per stage s (D_s = 2^(4-s)), the block keeps:
  - `v_s`: input-valid
  - `f_s`: input-first
  - `c_s`: a 5-bit counter
  - `primed_s`
- Stage 0 inputs: `v_0 = in_valid`, `f_0 = in_valid & in_first`.
- `c_s` increments on `v_s` and wraps 31->0. On `v_s & f_s` it loads 1; the current sample is treated as count 0.
- `stage_en[s] = v_s`.
- `bf_sel[s] = v_s & c_s[4-s]` (the count value for the current sample). It is 0 when `v_s` is low.
- `tw_addr` for stage s is `(c_s mod D_s) << s`, truncated to 4 bits, and is valid when `v_s & !bf_sel[s] & primed_s`. At all other times it is 0. Stage 4 is always 0.
- `primed_s` sets on the D_s-th valid input after reset and stays set until reset.
- Stage s output valid: `vo_s = v_s & primed_s`. Output first: `fo_s = vo_s & (c_s == D_s)`.
- `v_(s+1)` and `f_(s+1)` are `vo_s` and `fo_s` delayed by STAGE_LAT cycles (shift registers).
- Outputs:
  - `out_valid` and `out_first` are `vo_4` and `fo_4` delayed STAGE_LAT.
  - Output counter `k` loads 1 on `out_first` and increments on `out_valid`.
  - `out_idx` is `bitrev5` of the current sample's count.
- Gaps in `in_valid` propagate; no counter or select advances on an invalid cycle.

## Timing
- Reset: all outputs 0. Every `c_s`, `primed_s`, `k` and delay register is 0 and `err_sync` is 0. Reset is asynchronous in both assertion and release.
- Reset mid-frame discards all in-flight state. The first valid after reset is treated as count 0 whether or not `in_first` is set.
- Latency, continuous input: input sample 0 at cycle 0 gives `out_first` at cycle 31 + 5*STAGE_LAT (36 for the default).
- With gaps, latency is 31 valid input samples plus 5*STAGE_LAT cycles.
- Back-to-back frames give continuous `out_valid` with no bubbles. `out_first` recurs every 32 output samples.
- The pipeline holds its last partial contents when input stops. It does not flush.

## Configuration
- `IFFT_SYNC_CHECK_EN` defined:
  - `in_first` with `in_valid` while `c_0 != 0` sets `err_sync` on the next edge (sticky until reset).
  - The same event resynchronises `c_0` (loads 1). Downstream stages realign through `f_s`.
- Not defined:
  - `in_first` is honoured only for the first valid sample after reset; later it is ignored.
  - `c_0` free-runs.
  - `err_sync` is tied to 0.

## Test plan
- Reset check: hold `rst` low with toggling inputs -> every output stays 0. Release `rst`, then 32 valids -> `bf_sel[0]` is 0 for samples 0-15 and 1 for samples 16-31.
- Single continuous frame, STAGE_LAT=1, `in_first` on sample 0 at cycle 0 -> `out_first` at cycle 36. `out_idx` runs 0,16,8,24,4,20,...,31.
- Two back-to-back frames -> `out_valid` high for 64 consecutive cycles. `out_first` at cycles 36 and 68. During second-frame samples 32-47, stage 0 `tw_addr` is 0..15 and stage 1 `tw_addr` is 0,2,...,14 in its drain phase.
- `in_valid` on alternate cycles -> `bf_sel` and `tw_addr` advance only on valid cycles and are 0 on invalid ones. `out_first` arrives after 31 valid inputs plus 5 cycles (cycle 67 when the first input is at cycle 0).
- With `IFFT_SYNC_CHECK_EN`, `in_first` at sample 10 -> `err_sync` is 1 from the next cycle. `c_0` restarts so that sample 10 becomes count 0. `out_first` fires 36 cycles after that sample.
- Without the macro, the same stimulus -> `err_sync` stays 0 and the frame alignment is unchanged.
